// File: rtl/tdm_mux_16x1.sv
// tdm_mux_16x1: sixteen-channel time-division serializer.
// Accepts one 16-bit word per frame over valid/ready, then shifts it out one
// channel per clock on y with the matching channel index on s. The index drives
// the select of the downstream 1x16 demux.
// Optional feature macro: TDM_MUX_PARITY_EN appends a 17th, even-parity slot.
module tdm_mux_16x1 #(
  parameter int unsigned GAP = 0  // idle cycles after each frame's final slot (0..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        y,
  output logic [3:0]  s,
  output logic        y_valid,
  output logic        frame_start,
  output logic        par_slot
);

`ifdef TDM_MUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic [4:0] PAR_SLOT  = 5'd16;
  localparam logic [4:0] LAST_SLOT = PARITY_EN ? PAR_SLOT : 5'd15;
  localparam bit         HAS_GAP   = (GAP > 0);
  // The gap counter counts down to zero, so it is loaded with GAP-1.
  localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  slot_q, slot_d;    // slot currently on the outputs
  logic [15:0] frame_q, frame_d;
  logic [3:0]  gap_q, gap_d;
  logic        accept;

  logic        y_q, y_d;
  logic [3:0]  s_q, s_d;
  logic        y_valid_q, y_valid_d;
  logic        frame_start_q, frame_start_d;

  // Ready is a pure function of state: idle, or the final slot when frames may abut.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      in_ready = 1'b1;
    end else if (state_q == ST_SEND && slot_q == LAST_SLOT && !HAS_GAP) begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state logic: sequence the slots, then gap or idle, or reload on accept.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          slot_d  = 5'd0;
          frame_d = d;
        end
      end
      ST_SEND: begin
        if (slot_q != LAST_SLOT) begin
          slot_d = slot_q + 5'd1;
        end else if (accept) begin
          slot_d  = 5'd0;
          frame_d = d;
        end else if (HAS_GAP) begin
          state_d = ST_GAP;
          slot_d  = 5'd0;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
          slot_d  = 5'd0;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode for the slot being loaded, so the outputs register with the state.
  always_comb begin
    y_d           = 1'b0;
    s_d           = 4'd0;
    y_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == ST_SEND) begin
      y_valid_d     = 1'b1;
      frame_start_d = (slot_d == 5'd0);
      if (PARITY_EN && slot_d == PAR_SLOT) begin
        y_d = ^frame_d;
        s_d = 4'hF;
      end else begin
        y_d = frame_d[slot_d[3:0]];
        s_d = slot_d[3:0];
      end
    end
  end

  // State, frame register and registered outputs; reset clears all of them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_q        <= 5'd0;
      frame_q       <= 16'd0;
      gap_q         <= 4'd0;
      y_q           <= 1'b0;
      s_q           <= 4'd0;
      y_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the same
      // pre-edge values, whatever order these statements are written in.
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_q       <= frame_d;
      gap_q         <= gap_d;
      y_q           <= y_d;
      s_q           <= s_d;
      y_valid_q     <= y_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign y           = y_q;
  assign s           = s_q;
  assign y_valid     = y_valid_q;
  assign frame_start = frame_start_q;

`ifdef TDM_MUX_PARITY_EN
  logic par_slot_q, par_slot_d;

  // Parity-slot flag for the slot being loaded.
  always_comb begin
    par_slot_d = (state_d == ST_SEND) && (slot_d == PAR_SLOT);
  end

  // Registered parity-slot flag, cleared with the other outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_slot_q <= 1'b0;
    end else begin
      par_slot_q <= par_slot_d;
    end
  end

  assign par_slot = par_slot_q;
`else
  assign par_slot = 1'b0;
`endif

endmodule
